// File: rtl/cb_buffer_pkg.sv
// Shared types and register map for the connection-box input buffer.
package cb_buffer_pkg;
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_REG    = 2'd1,
    MODE_FIFO   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam int MODE_OFS  = 0;
  localparam int STAT_OFS  = 1;
  localparam int FLUSH_BIT = 2;
  localparam int STALL_W   = 16;
endpackage

// File: rtl/cb_buffer_fifo.sv
// Circular-buffer storage; i_one caps occupancy at a single entry for the REG stage.
module cb_buffer_fifo #(
  parameter  int WIDTH = 7,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic             i_one,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wr_ptr, r_rd_ptr;
  logic [AW:0]                 r_count;
  logic                        w_push, w_pop;

  assign o_full  = i_one ? (r_count != '0) : (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A push into a full stage is legal only when the head leaves the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/cb_core_input_buffer.sv
// CB-to-core input stage: bypass, single register or FIFO, with config readback and stall counter.
module cb_core_input_buffer
  import cb_buffer_pkg::*;
#(
  parameter int         WIDTH    = 7,
  parameter int         DEPTH    = 4,
  parameter logic [7:0] CFG_ADDR = 8'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      config_addr,
  input  logic [31:0]      config_data,
  input  logic             config_en,
  output logic [31:0]      read_data,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int         AW        = $clog2(DEPTH);
  localparam logic [7:0] MODE_ADDR = CFG_ADDR + 8'(MODE_OFS);
  localparam logic [7:0] STAT_ADDR = CFG_ADDR + 8'(STAT_OFS);

  mode_e               r_mode;
  logic [STALL_W-1:0]  r_stall;
  mode_e               w_new_mode;
  logic                w_mode_wr, w_flush, w_reg_mode, w_buf_mode;
  logic                w_in_ready, w_out_valid, w_push, w_pop;
  logic [WIDTH-1:0]    w_out_data, w_q;
  logic [AW:0]         w_count;
  logic [3:0]          w_cnt4;
  logic                w_full, w_empty;

  assign w_new_mode = mode_e'(config_data[1:0]);
  assign w_mode_wr  = config_en & (config_addr[7:0] == MODE_ADDR);
  // Any mode change or explicit flush discards buffered data on the write edge.
  assign w_flush    = w_mode_wr & (config_data[FLUSH_BIT] | (w_new_mode != r_mode));
  assign w_reg_mode = (r_mode == MODE_REG);
  assign w_buf_mode = w_reg_mode | (r_mode == MODE_FIFO);

  cb_buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_one   (w_reg_mode),
    .i_data  (in_data),
    .o_data  (w_q),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_in_ready  = out_ready;
    w_out_valid = in_valid;
    w_out_data  = in_data;
    if (w_buf_mode) begin
      w_out_valid = ~w_empty;
      w_out_data  = w_q;
      w_in_ready  = ~w_full | (w_reg_mode & out_ready);
    end
    if (w_flush) w_in_ready = 1'b0;
  end

  assign w_push = w_buf_mode & in_valid & w_in_ready;
  assign w_pop  = w_buf_mode & w_out_valid & out_ready;

  // Bypass is combinational, so outputs are forced explicitly while reset is held.
  assign in_ready  = ~reset | w_in_ready;
  assign out_valid = reset & w_out_valid;
  assign out_data  = reset ? w_out_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode  <= MODE_BYPASS;
      r_stall <= '0;
    end else begin
      if (w_mode_wr) r_mode <= w_new_mode;
      if (in_valid & ~w_in_ready & (r_stall != {STALL_W{1'b1}}))
        r_stall <= r_stall + 1'b1;
    end
  end

  assign w_cnt4 = 4'(w_count);

  always_comb begin
    read_data = '0;
    if (config_addr[7:0] == MODE_ADDR)      read_data = {29'b0, 1'b0, r_mode};
    else if (config_addr[7:0] == STAT_ADDR) read_data = {r_stall, 12'b0, w_cnt4};
  end
endmodule

// File: tb/tb_cb_core_input_buffer.sv
// Directed checks plus randomized REG/FIFO traffic against a queue-based scoreboard.
module tb_cb_core_input_buffer;
  localparam int WIDTH = 7;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      config_addr, config_data;
  logic             config_en;
  logic [31:0]      read_data;
  logic [WIDTH-1:0] in_data;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall = 0;
  int m_cnt = 0;
  logic mon_en = 1'b0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_d;

  cb_core_input_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CFG_ADDR(8'd0)) dut (
    .clk(clk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .read_data(read_data), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [31:0] d);
    config_addr = 32'd0;
    config_data = d;
    config_en   = 1'b1;
    tick();
    config_en   = 1'b0;
  endtask

  task automatic chk_status(input string nm, input int stall, input int cnt);
    config_addr = 32'd1;
    #1;
    chk(nm, read_data, {16'(stall), 12'b0, 4'(cnt)});
    config_addr = 32'd0;
    #1;
  endtask

  // Reference: REG holds one item and accepts when empty or draining; FIFO holds DEPTH.
  task automatic run_rand(input int n, input bit is_reg);
    bit rdy, push, pop;
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      rdy = is_reg ? (m_cnt == 0 || out_ready) : (m_cnt < DEPTH);
      chk("sb_in_ready", 32'(in_ready), 32'(rdy));
      @(posedge clk);
      push = in_valid && rdy;
      pop  = out_ready && (m_cnt > 0);
      if (in_valid && !rdy) exp_stall++;
      if (push) exp_q.push_back(in_data);
      m_cnt = m_cnt + int'(push) - int'(pop);
      #1;
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("sb_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        chk("sb_out_data", 32'(out_data), 32'(exp_d));
      end
    end
  end

  initial begin
    reset = 1'b0; config_en = 1'b0; config_addr = 32'd0; config_data = 32'd0;
    in_data = 7'd5; in_valid = 1'b1; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_rst_read", read_data, 32'd0);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    in_data = 7'd4; in_valid = 1'b1;
    #1;
    chk("byp_data", 32'(out_data), 32'd4);
    chk("byp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;

    cfg_write(32'd1);
    in_data = 7'd34; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("reg_empty_valid", 32'(out_valid), 32'd0);
    tick();
    chk("reg_valid", 32'(out_valid), 32'd1);
    chk("reg_data", 32'(out_data), 32'd34);
    in_valid = 1'b0;
    #1;
    chk("reg_blocked", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("reg_pass_ready", 32'(in_ready), 32'd1);
    tick();
    chk("reg_drained", 32'(out_valid), 32'd0);

    cfg_write(32'd2);
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_data = WIDTH'(k); in_valid = 1'b1;
      if (k == 5) begin
        #1;
        chk("fifo_full_ready", 32'(in_ready), 32'd0);
      end
      tick();
    end
    in_valid = 1'b0;
    exp_stall = 1;
    chk_status("fifo_full_status", exp_stall, 4);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("fifo_pop_data", 32'(out_data), 32'(k));
      tick();
    end
    chk("fifo_empty", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    for (int k = 10; k <= 11; k++) begin
      in_data = WIDTH'(k); in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = WIDTH'(12 + k); in_valid = 1'b1;
      #1;
      chk("wrap_data", 32'(out_data), 32'(10 + k));
      tick();
      chk_status("wrap_count", exp_stall, 2);
    end
    in_valid = 1'b0;
    for (int k = 16; k <= 17; k++) begin
      chk("wrap_drain", 32'(out_data), 32'(k));
      tick();
    end

    out_ready = 1'b0;
    for (int k = 20; k <= 22; k++) begin
      in_data = WIDTH'(k); in_valid = 1'b1;
      tick();
    end
    config_addr = 32'd0; config_data = 32'h6; config_en = 1'b1;
    in_data = 7'd99; in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    config_en = 1'b0; in_valid = 1'b0;
    exp_stall = 2;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk_status("flush_status", exp_stall, 0);
    chk("flush_mode_read", read_data, 32'h2);

    cfg_write(32'd1);
    m_cnt = 0; exp_q.delete();
    mon_en = 1'b1;
    run_rand(300, 1'b1);
    mon_en = 1'b0;
    chk_status("rand_reg_status", exp_stall, m_cnt);

    cfg_write(32'd2);
    m_cnt = 0; exp_q.delete();
    mon_en = 1'b1;
    run_rand(400, 1'b0);
    mon_en = 1'b0;
    chk_status("rand_fifo_status", exp_stall, m_cnt);

    cfg_write(32'h6);
    out_ready = 1'b0;
    for (int k = 40; k <= 42; k++) begin
      in_data = WIDTH'(k); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk_status("pre_reset_count", exp_stall, 3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk_status("midrst_status", 0, 0);
    chk("midrst_mode", read_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("after_rst_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
